fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Upstream fetch/sequencing stage of the 16-bit CPU.
- Owns the program counter and feeds the instruction decoder its current instruction word and immediate operand N.
- Takes the decoder's PC-control outputs (cnt_en, pc_sload, new_pc) and the synchronous instruction-memory read data.
- Handles boot priming, data-path stalls and STP halt/resume, and emits a commit qualifier used to gate all architectural write enables.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'h0000, word driven on instr while no valid fetch exists (decodes as NOP).
- STP_OPCODE, 5'b11111, value of instr[15:11] that halts the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  from decoder: increment PC on commit.
- pc_sload  in  1  from decoder: load new_pc on commit; priority over cnt_en.
- new_pc  in  16  from decoder: PC load value.
- stall  in  1  data path not ready; current instruction must not commit.
- resume  in  1  single-cycle pulse; leave HALT.
- instr_q1  in  16  instruction memory port-1 read data (1-cycle latency).
- instr_q2  in  16  instruction memory port-2 read data (1-cycle latency).
- pc  out  16  program counter; points to the word after the current instruction.
- instr  out  16  instruction word presented to the decoder.
- N  out  16  immediate/operand word presented to the decoder.
- commit  out  1  current instr takes effect this cycle.
- halted  out  1  sequencer in HALT.
- state  out  2  BOOT=00, RUN=01, STALL=10, HALT=11 (debug).
- commit_count  out  32  see Optional Feature.
- stall_count  out  16  see Optional Feature.

Behaviour:
- Reset (async, reset_n=0):
  - state=BOOT, pc=RESET_PC, held instr/N regs=NOP_WORD/16'h0000.
  - Outputs commit=0, halted=0.
- BOOT, one cycle:
  - instr=NOP_WORD, N=0, commit=0.
  - pc<=pc+1 unconditionally; decoder inputs are ignored.
  - Next state RUN. With NOP the decoder addresses pc and pc+1, so on the first RUN cycle instr=mem[RESET_PC] and N=mem[RESET_PC+1].
- RUN:
  - instr=instr_q1, N=instr_q2.
  - Held regs load instr_q1/instr_q2 every RUN cycle.
  - commit=!stall.
  - stall=1: next STALL, pc unchanged.
  - stall=0 and instr[15:11]==STP_OPCODE: commit=1, next HALT, pc unchanged.
  - Otherwise stay RUN.
- STALL:
  - instr/N driven from held regs; memory data ignored.
  - pc frozen while stall=1, commit=0.
  - Cycle stall drops: commit=1 using held word, PC update applied, next RUN (or HALT if held word is STP).
  - Stall may persist any number of cycles.
- PC update, only when commit=1:
  - pc_sload=1: pc<=new_pc.
  - else cnt_en=1: pc<=pc+1, 16-bit wrap (16'hFFFF to 16'h0000).
  - else pc holds.
- HALT:
  - instr=held STP word, N=held, commit=0, halted=1, pc frozen.
  - resume=1: next BOOT, pc unchanged, so execution restarts at the word after STP.
  - resume outside HALT is ignored.
- Simultaneous events:
  - stall in the same cycle as an STP in RUN: stall wins; HALT is taken on the STALL exit commit.
  - reset_n low in any state returns to BOOT immediately, including mid-stall; held regs are cleared.
- Latency: one BOOT bubble after reset or resume; zero bubbles after a stall; no bubble on jumps, since the decoder presents target addresses combinationally.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - commit_count increments on every commit=1 cycle (32-bit, wraps).
  - stall_count increments on every cycle with state RUN or STALL and stall=1 (16-bit, saturates at 16'hFFFF).
  - Both clear on reset.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, memory mem[0]=16'h0000 (NOP), mem[1]=16'h1234 -> BOOT 1 cycle, then state=RUN, instr=16'h0000, N=16'h1234, pc=16'h0001.
- RUN, cnt_en=1, pc=16'hFFFF -> pc=16'h0000 next cycle, commit=1.
- RUN, pc_sload=1, cnt_en=1, new_pc=16'h0040 -> pc=16'h0040 (sload priority).
- RUN instr=16'h4001, stall high 3 cycles while instr_q1 driven 16'hDEAD -> instr stays 16'h4001, commit=0 for 3 cycles, pc frozen; the drop cycle commits once; next cycle state=RUN.
- RUN instr=16'hF800 (STP), pc=16'h0010 -> state=HALT, halted=1, pc=16'h0010; resume pulse -> BOOT then RUN, instr=mem[16'h0010], pc=16'h0011.
- reset_n asserted mid-STALL with pc=16'h0022 -> immediately state=BOOT, pc=RESET_PC, commit=0; with FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch/sequencing front end of the 16-bit CPU. Owns the program counter and
// presents the current instruction word and its immediate operand N to the
// decoder. Handles boot priming after reset/resume, data-path stalls, STP
// halt/resume, and produces the commit qualifier that gates all architectural
// write enables downstream.
//
// Build option:
//   FETCH_PERF_EN  when defined, commit_count / stall_count are live counters;
//                  when undefined, both ports are tied to zero and no counter
//                  flops exist.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   cnt_en        in   decoder: increment PC on commit
//   pc_sload      in   decoder: load new_pc on commit (beats cnt_en)
//   new_pc[15:0]  in   decoder: PC load value
//   stall         in   data path not ready; current instruction must not commit
//   resume        in   single-cycle pulse that leaves HALT
//   instr_q1      in   instruction memory port-1 read data (1-cycle latency)
//   instr_q2      in   instruction memory port-2 read data (1-cycle latency)
//   pc[15:0]      out  program counter (word after the current instruction)
//   instr[15:0]   out  instruction word for the decoder
//   N[15:0]       out  immediate/operand word for the decoder
//   commit        out  current instruction takes effect this cycle
//   halted        out  sequencer is in HALT
//   state[1:0]    out  BOOT=00, RUN=01, STALL=10, HALT=11
//   commit_count  out  number of committed instructions (optional)
//   stall_count   out  saturating count of stalled cycles (optional)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_WORD   = 16'h0000,
   parameter logic [4:0]  STP_OPCODE = 5'b11111
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cnt_en,
   input  logic        pc_sload,
   input  logic [15:0] new_pc,
   input  logic        stall,
   input  logic        resume,
   input  logic [15:0] instr_q1,
   input  logic [15:0] instr_q2,
   output logic [15:0] pc,
   output logic [15:0] instr,
   output logic [15:0] N,
   output logic        commit,
   output logic        halted,
   output logic [1:0]  state,
   output logic [31:0] commit_count,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10,
      ST_HALT  = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] held_instr_q, held_instr_d;
   logic [15:0] held_n_q, held_n_d;

   logic [15:0] instr_s;
   logic [15:0] n_s;
   logic        commit_s;
   logic        is_stp_s;
   logic [15:0] pc_upd_s;

   // Select the word pair shown to the decoder and derive the commit qualifier.
   always_comb begin
      instr_s  = NOP_WORD;
      n_s      = 16'h0000;
      commit_s = 1'b0;
      case (state_q)
         ST_BOOT: begin
            instr_s  = NOP_WORD;
            n_s      = 16'h0000;
            commit_s = 1'b0;
         end
         ST_RUN: begin
            instr_s  = instr_q1;
            n_s      = instr_q2;
            commit_s = ~stall;
         end
         ST_STALL: begin
            // Memory has moved on; the stalled instruction lives in the held regs.
            instr_s  = held_instr_q;
            n_s      = held_n_q;
            commit_s = ~stall;
         end
         ST_HALT: begin
            instr_s  = held_instr_q;
            n_s      = held_n_q;
            commit_s = 1'b0;
         end
         default: begin
            instr_s  = NOP_WORD;
            n_s      = 16'h0000;
            commit_s = 1'b0;
         end
      endcase
   end

   assign is_stp_s = (instr_s[15:11] == STP_OPCODE);

   // PC value applied by a committing non-STP instruction; sload beats cnt_en.
   always_comb begin
      pc_upd_s = pc_q;
      if (pc_sload) begin
         pc_upd_s = new_pc;
      end else if (cnt_en) begin
         pc_upd_s = pc_q + 16'd1;
      end else begin
         pc_upd_s = pc_q;
      end
   end

   // Next-state, PC and held-word computation.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      held_instr_d = held_instr_q;
      held_n_d     = held_n_q;
      case (state_q)
         ST_BOOT: begin
            // NOP is on the decoder, so it addresses pc/pc+1; step past them.
            pc_d    = pc_q + 16'd1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            held_instr_d = instr_q1;
            held_n_d     = instr_q2;
            if (stall) begin
               state_d = ST_STALL;
            end else if (is_stp_s) begin
               // STP leaves pc on the following word so resume restarts there.
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_upd_s;
               state_d = ST_RUN;
            end
         end
         ST_STALL: begin
            if (stall) begin
               state_d = ST_STALL;
            end else if (is_stp_s) begin
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_upd_s;
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d = ST_BOOT;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Sequencer state, program counter and held instruction registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         held_instr_q <= NOP_WORD;
         held_n_q     <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         held_instr_q <= held_instr_d;
         held_n_q     <= held_n_d;
      end
   end

   assign pc     = pc_q;
   assign instr  = instr_s;
   assign N      = n_s;
   assign commit = commit_s;
   assign halted = (state_q == ST_HALT);
   assign state  = state_q;

`ifdef FETCH_PERF_EN
   logic [31:0] commit_cnt_q;
   logic [15:0] stall_cnt_q;
   logic        stall_evt_s;

   assign stall_evt_s = stall & ((state_q == ST_RUN) | (state_q == ST_STALL));

   // Performance counters: wrapping commit count, saturating stall count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_cnt_q <= 32'd0;
         stall_cnt_q  <= 16'd0;
      end else begin
         if (commit_s) begin
            commit_cnt_q <= commit_cnt_q + 32'd1;
         end
         if (stall_evt_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign commit_count = commit_cnt_q;
   assign stall_count  = stall_cnt_q;
`else
   assign commit_count = 32'd0;
   assign stall_count  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_sequencer. A stimulus process drives one cycle at a time
// and pushes the expected outputs computed by a behavioural model; a monitor
// process pops and compares against the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk;
   logic        reset_n;
   logic        cnt_en;
   logic        pc_sload;
   logic [15:0] new_pc;
   logic        stall;
   logic        resume;
   logic [15:0] instr_q1;
   logic [15:0] instr_q2;
   logic [15:0] pc;
   logic [15:0] instr;
   logic [15:0] N;
   logic        commit;
   logic        halted;
   logic [1:0]  state;
   logic [31:0] commit_count;
   logic [15:0] stall_count;

   fetch_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cnt_en       (cnt_en),
      .pc_sload     (pc_sload),
      .new_pc       (new_pc),
      .stall        (stall),
      .resume       (resume),
      .instr_q1     (instr_q1),
      .instr_q2     (instr_q2),
      .pc           (pc),
      .instr        (instr),
      .N            (N),
      .commit       (commit),
      .halted       (halted),
      .state        (state),
      .commit_count (commit_count),
      .stall_count  (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] n;
      logic        commit;
      logic        halted;
      logic [1:0]  state;
      logic [31:0] ccnt;
      logic [15:0] scnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0=BOOT 1=RUN 2=STALL 3=HALT
   int          m_mode;
   logic [15:0] m_pc;
   logic [15:0] m_hi;
   logic [15:0] m_hn;
   logic [31:0] m_cc;
   logic [15:0] m_sc;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_pc   = RST_PC;
      m_hi   = 16'h0000;
      m_hn   = 16'h0000;
      m_cc   = 32'd0;
      m_sc   = 16'd0;
   endtask

   // Drive one cycle, push the expected outputs, then advance the model.
   task automatic cycle(input logic rn, input logic st, input logic rs, input logic ce,
                        input logic sl, input logic [15:0] np, input logic [15:0] q1,
                        input logic [15:0] q2);
      exp_t        e;
      logic [15:0] cur;
      logic [15:0] cur_n;
      logic        cm;
      @(negedge clk);
      reset_n  = rn;
      stall    = st;
      resume   = rs;
      cnt_en   = ce;
      pc_sload = sl;
      new_pc   = np;
      instr_q1 = q1;
      instr_q2 = q2;
      if (!rn) model_reset();
      if (m_mode == 0) begin
         cur = 16'h0000; cur_n = 16'h0000;
      end else if (m_mode == 1) begin
         cur = q1; cur_n = q2;
      end else begin
         cur = m_hi; cur_n = m_hn;
      end
      cm = ((m_mode == 1) || (m_mode == 2)) && !st;
      e.pc     = m_pc;
      e.instr  = cur;
      e.n      = cur_n;
      e.commit = cm;
      e.halted = (m_mode == 3);
      e.state  = 2'(m_mode);
`ifdef FETCH_PERF_EN
      e.ccnt   = m_cc;
      e.scnt   = m_sc;
`else
      e.ccnt   = 32'd0;
      e.scnt   = 16'd0;
`endif
      exp_q.push_back(e);
      if (rn) begin
         case (m_mode)
            0: begin
               m_pc   = m_pc + 16'd1;
               m_mode = 1;
            end
            1, 2: begin
               if (m_mode == 1) begin
                  m_hi = q1; m_hn = q2;
               end
               if (st) begin
                  m_mode = 2;
                  if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
               end else begin
                  m_cc = m_cc + 32'd1;
                  if (cur[15:11] == 5'b11111) begin
                     m_mode = 3;
                  end else begin
                     if (sl) m_pc = np;
                     else if (ce) m_pc = m_pc + 16'd1;
                     m_mode = 1;
                  end
               end
            end
            default: begin
               if (rs) m_mode = 0;
            end
         endcase
      end
   endtask

   // Monitor: compare DUT outputs with the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",           32'(pc),           32'(e.pc));
            chk("instr",        32'(instr),        32'(e.instr));
            chk("N",            32'(N),            32'(e.n));
            chk("commit",       32'(commit),       32'(e.commit));
            chk("halted",       32'(halted),       32'(e.halted));
            chk("state",        32'(state),        32'(e.state));
            chk("commit_count", commit_count,      e.ccnt);
            chk("stall_count",  32'(stall_count),  32'(e.scnt));
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      logic [15:0] rq1;
      reset_n  = 1'b0;
      stall    = 1'b0;
      resume   = 1'b0;
      cnt_en   = 1'b0;
      pc_sload = 1'b0;
      new_pc   = 16'h0000;
      instr_q1 = 16'h0000;
      instr_q2 = 16'h0000;
      model_reset();

      // Reset, boot bubble, first RUN word pair.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'hAAAA, 16'hBBBB);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234);
      // Jump to FFFF, then increment wraps to 0000.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      // sload priority over cnt_en.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      // Three-cycle stall on 4001 with memory showing DEAD.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h4001, 16'h0007);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hDEAD, 16'hDEAD);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hDEAD, 16'hDEAD);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hDEAD, 16'hDEAD);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      // STP at pc=0010, halt, stray stall ignored, resume.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hF800, 16'h0000);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 16'h2222);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1111, 16'h2222);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 16'h2222);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h3333, 16'h4444);
      // Stall coinciding with STP: HALT taken on the stall exit.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hF801, 16'h0009);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      // Reset in the middle of a stall at pc=0022.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0022, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h4002, 16'h0000);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rq1 = 16'($urandom);
         if ($urandom_range(0, 9) == 0) rq1[15:11] = 5'b11111;
         cycle(($urandom_range(0, 249) != 0),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 7) == 0),
               (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom)),
               rq1,
               16'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
